// File: rtl/xcore_bpu_cmt_unit.sv
// xcore_bpu_cmt_unit: in-order queue of fetch-time branch predictions.
// Each prediction is checked against its execute-stage resolution and the
// block emits the commit feedback for the predictor: GHR repair, BIM
// counter update, BTB write data, and a fetch flush/redirect on mispredict.
module xcore_bpu_cmt_unit #(
    parameter int WIDTH  = 32,
    parameter int GHRLEN = 2,
    parameter int DEPTH  = 4,
    parameter int CNTW   = 3
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_bpu_push,
    input  logic [WIDTH-1:0]  i_bpu_pc,
    input  logic [GHRLEN-1:0] i_bpu_ghr,
    input  logic [1:0]        i_bpu_bits,
    input  logic              i_bpu_redir,
    input  logic [WIDTH-1:0]  i_bpu_target,
    input  logic              i_ex_vld,
    input  logic [2:0]        i_ex_type,
    input  logic              i_ex_taken,
    input  logic [WIDTH-1:0]  i_ex_target,
    output logic              o_cmt_req,
    output logic              o_cmt_ghr,
    output logic              o_cmt_ghr_target,
    output logic [GHRLEN-1:0] o_cmt_ghr_val,
    output logic [1:0]        o_cmt_bits,
    output logic [WIDTH-1:0]  o_wb_instr_pc,
    output logic [2:0]        o_wb_cmt_type,
    output logic [WIDTH-1:0]  o_wb_cmt_target,
    output logic              o_flush,
    output logic [WIDTH-1:0]  o_flush_pc,
    output logic              o_q_full,
    output logic              o_q_empty,
    output logic [CNTW-1:0]   o_q_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [2:0] TYPE_BRANCH = 3'b001;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_RECOV = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic              cmt_req_q, cmt_req_d;
    logic              cmt_ghr_q, cmt_ghr_d;
    logic              cmt_ghr_target_q, cmt_ghr_target_d;
    logic [GHRLEN-1:0] cmt_ghr_val_q, cmt_ghr_val_d;
    logic [1:0]        cmt_bits_q, cmt_bits_d;
    logic [WIDTH-1:0]  wb_instr_pc_q, wb_instr_pc_d;
    logic [2:0]        wb_cmt_type_q, wb_cmt_type_d;
    logic [WIDTH-1:0]  wb_cmt_target_q, wb_cmt_target_d;
    logic              flush_q, flush_d;
    logic [WIDTH-1:0]  flush_pc_q, flush_pc_d;

    // Prediction storage, one slot per in-flight control instruction.
    logic [WIDTH-1:0]  ent_pc_q    [DEPTH];
    logic [GHRLEN-1:0] ent_ghr_q   [DEPTH];
    logic [1:0]        ent_bits_q  [DEPTH];
    logic              ent_redir_q [DEPTH];
    logic [WIDTH-1:0]  ent_tgt_q   [DEPTH];

    logic              q_full, q_empty, in_run;
    logic              pop, push_ok;
    logic [WIDTH-1:0]  head_pc, head_tgt;
    logic [GHRLEN-1:0] head_ghr;
    logic [1:0]        head_bits;
    logic              head_redir;
    logic              is_branch, taken_eff, mispredict;
    logic [1:0]        bits_upd;

    // Queue status, head fields and resolution compare.
    always_comb begin
        q_full     = (cnt_q == CNTW'(DEPTH));
        q_empty    = (cnt_q == '0);
        in_run     = (state_q == ST_RUN);
        pop        = in_run & i_ex_vld & ~q_empty;

        head_pc    = ent_pc_q[rd_q];
        head_ghr   = ent_ghr_q[rd_q];
        head_bits  = ent_bits_q[rd_q];
        head_redir = ent_redir_q[rd_q];
        head_tgt   = ent_tgt_q[rd_q];

        is_branch  = (i_ex_type == TYPE_BRANCH);
        taken_eff  = is_branch ? i_ex_taken : 1'b1;
        mispredict = (head_redir != taken_eff) |
                     (taken_eff & head_redir & (head_tgt != i_ex_target));

        // Saturating 2-bit counter for branches; jumps are always strongly taken.
        if (!is_branch) begin
            bits_upd = 2'b11;
        end else if (taken_eff) begin
            bits_upd = (head_bits == 2'b11) ? 2'b11 : head_bits + 2'b01;
        end else begin
            bits_upd = (head_bits == 2'b00) ? 2'b00 : head_bits - 2'b01;
        end

        // A push in the same cycle as a mispredict pop is wrong-path.
        push_ok = in_run & i_bpu_push & ~q_full & ~(pop & mispredict);
    end

    // Next-state for pointers, count, FSM and the registered commit bus.
    always_comb begin
        // NOTE: every signal gets a default before any branch, otherwise a path that
        // skips an assignment makes the tool infer a latch.
        state_d          = state_q;
        rd_d             = rd_q;
        wr_d             = wr_q;
        cnt_d            = cnt_q;
        cmt_req_d        = 1'b0;
        flush_d          = 1'b0;
        cmt_ghr_d        = cmt_ghr_q;
        cmt_ghr_target_d = cmt_ghr_target_q;
        cmt_ghr_val_d    = cmt_ghr_val_q;
        cmt_bits_d       = cmt_bits_q;
        wb_instr_pc_d    = wb_instr_pc_q;
        wb_cmt_type_d    = wb_cmt_type_q;
        wb_cmt_target_d  = wb_cmt_target_q;
        flush_pc_d       = flush_pc_q;

        if (state_q == ST_RECOV) begin
            state_d = ST_RUN;
        end

        if (pop) begin
            cmt_req_d        = 1'b1;
            cmt_ghr_d        = mispredict;
            cmt_ghr_target_d = taken_eff;
            // Shift the actual outcome into the history snapshot.
            cmt_ghr_val_d    = GHRLEN'({head_ghr, taken_eff});
            cmt_bits_d       = bits_upd;
            wb_instr_pc_d    = head_pc;
            wb_cmt_type_d    = i_ex_type;
            wb_cmt_target_d  = i_ex_target;
            flush_d          = mispredict;
            flush_pc_d       = taken_eff ? i_ex_target : head_pc + WIDTH'(4);
            if (mispredict) begin
                // Everything younger than the head is on the wrong path.
                state_d = ST_RECOV;
                rd_d    = wr_q;
                cnt_d   = '0;
            end else begin
                rd_d  = rd_q + PW'(1);
                cnt_d = cnt_q - CNTW'(1);
            end
        end

        if (push_ok) begin
            wr_d  = wr_q + PW'(1);
            cnt_d = cnt_d + CNTW'(1);
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge i_sys_clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples
        // its _d value from before the edge, independent of statement order.
        if (i_sys_rst) begin
            state_q          <= ST_RUN;
            rd_q             <= '0;
            wr_q             <= '0;
            cnt_q            <= '0;
            cmt_req_q        <= 1'b0;
            cmt_ghr_q        <= 1'b0;
            cmt_ghr_target_q <= 1'b0;
            cmt_ghr_val_q    <= '0;
            cmt_bits_q       <= '0;
            wb_instr_pc_q    <= '0;
            wb_cmt_type_q    <= '0;
            wb_cmt_target_q  <= '0;
            flush_q          <= 1'b0;
            flush_pc_q       <= '0;
        end else begin
            state_q          <= state_d;
            rd_q             <= rd_d;
            wr_q             <= wr_d;
            cnt_q            <= cnt_d;
            cmt_req_q        <= cmt_req_d;
            cmt_ghr_q        <= cmt_ghr_d;
            cmt_ghr_target_q <= cmt_ghr_target_d;
            cmt_ghr_val_q    <= cmt_ghr_val_d;
            cmt_bits_q       <= cmt_bits_d;
            wb_instr_pc_q    <= wb_instr_pc_d;
            wb_cmt_type_q    <= wb_cmt_type_d;
            wb_cmt_target_q  <= wb_cmt_target_d;
            flush_q          <= flush_d;
            flush_pc_q       <= flush_pc_d;
        end
    end

    // Write accepted predictions into the slot at the write pointer.
    always_ff @(posedge i_sys_clk) begin
        // NOTE: the storage array has no reset; an entry is only read after it has
        // been written, because the count and pointers are reset.
        if (push_ok) begin
            ent_pc_q[wr_q]    <= i_bpu_pc;
            ent_ghr_q[wr_q]   <= i_bpu_ghr;
            ent_bits_q[wr_q]  <= i_bpu_bits;
            ent_redir_q[wr_q] <= i_bpu_redir;
            ent_tgt_q[wr_q]   <= i_bpu_target;
        end
    end

    assign o_cmt_req        = cmt_req_q;
    assign o_cmt_ghr        = cmt_ghr_q;
    assign o_cmt_ghr_target = cmt_ghr_target_q;
    assign o_cmt_ghr_val    = cmt_ghr_val_q;
    assign o_cmt_bits       = cmt_bits_q;
    assign o_wb_instr_pc    = wb_instr_pc_q;
    assign o_wb_cmt_type    = wb_cmt_type_q;
    assign o_wb_cmt_target  = wb_cmt_target_q;
    assign o_flush          = flush_q;
    assign o_flush_pc       = flush_pc_q;
    assign o_q_full         = q_full;
    assign o_q_empty        = q_empty;
    assign o_q_cnt          = cnt_q;

endmodule

// File: tb/tb_xcore_bpu_cmt_unit.sv
// Bench for xcore_bpu_cmt_unit: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the commit rules.
module tb_xcore_bpu_cmt_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        bpu_push;
    logic [31:0] bpu_pc;
    logic [1:0]  bpu_ghr;
    logic [1:0]  bpu_bits;
    logic        bpu_redir;
    logic [31:0] bpu_target;
    logic        ex_vld;
    logic [2:0]  ex_type;
    logic        ex_taken;
    logic [31:0] ex_target;

    logic        cmt_req, cmt_ghr, cmt_ghr_target, flush, q_full, q_empty;
    logic [1:0]  cmt_ghr_val, cmt_bits;
    logic [31:0] wb_instr_pc, wb_cmt_target, flush_pc;
    logic [2:0]  wb_cmt_type, q_cnt;

    xcore_bpu_cmt_unit dut (
        .i_sys_clk        (clk),
        .i_sys_rst        (rst),
        .i_bpu_push       (bpu_push),
        .i_bpu_pc         (bpu_pc),
        .i_bpu_ghr        (bpu_ghr),
        .i_bpu_bits       (bpu_bits),
        .i_bpu_redir      (bpu_redir),
        .i_bpu_target     (bpu_target),
        .i_ex_vld         (ex_vld),
        .i_ex_type        (ex_type),
        .i_ex_taken       (ex_taken),
        .i_ex_target      (ex_target),
        .o_cmt_req        (cmt_req),
        .o_cmt_ghr        (cmt_ghr),
        .o_cmt_ghr_target (cmt_ghr_target),
        .o_cmt_ghr_val    (cmt_ghr_val),
        .o_cmt_bits       (cmt_bits),
        .o_wb_instr_pc    (wb_instr_pc),
        .o_wb_cmt_type    (wb_cmt_type),
        .o_wb_cmt_target  (wb_cmt_target),
        .o_flush          (flush),
        .o_flush_pc       (flush_pc),
        .o_q_full         (q_full),
        .o_q_empty        (q_empty),
        .o_q_cnt          (q_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  ghr;
        logic [1:0]  bits;
        logic        redir;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    bit          m_recov;
    int          checks   = 0;
    int          failures = 0;

    logic        e_req, e_ghr, e_gt, e_flush;
    logic [1:0]  e_gv, e_bits;
    logic [31:0] e_pc, e_tgt, e_fpc;
    logic [2:0]  e_type;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: advance by one clock using the inputs currently applied.
    task automatic model_step();
        ent_t h;
        int   sz;
        bit   do_pop, mp, te;
        int   b;
        e_req   = 1'b0;
        e_flush = 1'b0;
        if (rst) begin
            mq.delete();
            m_recov = 0;
            {e_ghr, e_gt, e_gv, e_bits, e_pc, e_type, e_tgt, e_fpc} = '0;
            return;
        end
        if (m_recov) begin
            m_recov = 0;
            return;
        end
        sz     = mq.size();
        do_pop = ex_vld && (sz > 0);
        mp     = 0;
        if (do_pop) begin
            h  = mq[0];
            te = (ex_type == 3'b001) ? ex_taken : 1'b1;
            mp = (h.redir != te) || (te && h.redir && (h.tgt != ex_target));
            b  = int'(h.bits);
            if (ex_type != 3'b001) b = 3;
            else if (te)           b = (b == 3) ? 3 : b + 1;
            else                   b = (b == 0) ? 0 : b - 1;
            e_req   = 1'b1;
            e_ghr   = mp;
            e_gt    = te;
            e_gv    = 2'((int'(h.ghr) * 2 + int'(te)) % 4);
            e_bits  = 2'(b);
            e_pc    = h.pc;
            e_type  = ex_type;
            e_tgt   = ex_target;
            e_flush = mp;
            e_fpc   = te ? ex_target : h.pc + 32'd4;
            void'(mq.pop_front());
            if (mp) begin
                mq.delete();
                m_recov = 1;
            end
        end
        if (bpu_push && (sz < DEPTH) && !(do_pop && mp))
            mq.push_back('{bpu_pc, bpu_ghr, bpu_bits, bpu_redir, bpu_target});
    endtask

    task automatic compare_all();
        check("cmt_req", 32'(cmt_req), 32'(e_req));
        check("flush", 32'(flush), 32'(e_flush));
        check("q_cnt", 32'(q_cnt), 32'(mq.size()));
        check("q_full", 32'(q_full), 32'(mq.size() == DEPTH));
        check("q_empty", 32'(q_empty), 32'(mq.size() == 0));
        if (e_req) begin
            check("cmt_ghr", 32'(cmt_ghr), 32'(e_ghr));
            check("cmt_ghr_target", 32'(cmt_ghr_target), 32'(e_gt));
            check("cmt_ghr_val", 32'(cmt_ghr_val), 32'(e_gv));
            check("cmt_bits", 32'(cmt_bits), 32'(e_bits));
            check("wb_instr_pc", wb_instr_pc, e_pc);
            check("wb_cmt_type", 32'(wb_cmt_type), 32'(e_type));
            check("wb_cmt_target", wb_cmt_target, e_tgt);
            check("flush_pc", flush_pc, e_fpc);
        end
    endtask

    // One clock: model, edge, sample just after the edge, then release pulses.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        rst      = 1'b0;
        bpu_push = 1'b0;
        ex_vld   = 1'b0;
    endtask

    task automatic push_only(input logic [31:0] pc, input logic [1:0] ghr, input logic [1:0] bits,
                             input logic redir, input logic [31:0] tgt);
        bpu_push = 1'b1; bpu_pc = pc; bpu_ghr = ghr; bpu_bits = bits;
        bpu_redir = redir; bpu_target = tgt;
        cycle();
    endtask

    task automatic resolve(input logic [2:0] typ, input logic taken, input logic [31:0] tgt);
        ex_vld = 1'b1; ex_type = typ; ex_taken = taken; ex_target = tgt;
        cycle();
    endtask

    initial begin
        rst = 1'b1; bpu_push = 1'b0; bpu_pc = '0; bpu_ghr = '0; bpu_bits = '0;
        bpu_redir = 1'b0; bpu_target = '0; ex_vld = 1'b0; ex_type = 3'b001;
        ex_taken = 1'b0; ex_target = '0; m_recov = 0;
        cycle();
        rst = 1'b1;
        cycle();

        // Reset state.
        check("rst_req", 32'(cmt_req), 32'd0);
        check("rst_empty", 32'(q_empty), 32'd1);
        check("rst_cnt", 32'(q_cnt), 32'd0);
        check("rst_flush_pc", flush_pc, 32'd0);
        check("rst_bits", 32'(cmt_bits), 32'd0);

        // Correctly predicted not-taken branch.
        push_only(32'h100, 2'b01, 2'b01, 1'b0, 32'h0);
        resolve(3'b001, 1'b0, 32'h0);
        check("t1_req", 32'(cmt_req), 32'd1);
        check("t1_ghr", 32'(cmt_ghr), 32'd0);
        check("t1_bits", 32'(cmt_bits), 32'd0);
        check("t1_ghr_val", 32'(cmt_ghr_val), 32'h2);
        check("t1_flush", 32'(flush), 32'd0);
        check("t1_empty", 32'(q_empty), 32'd1);

        // Branch predicted not-taken but taken: flush, push during recovery dropped.
        push_only(32'h200, 2'b00, 2'b01, 1'b0, 32'h0);
        resolve(3'b001, 1'b1, 32'h240);
        check("t2_ghr", 32'(cmt_ghr), 32'd1);
        check("t2_bits", 32'(cmt_bits), 32'h2);
        check("t2_flush", 32'(flush), 32'd1);
        check("t2_flush_pc", flush_pc, 32'h240);
        push_only(32'h210, 2'b00, 2'b00, 1'b0, 32'h0);
        check("t2_recov_push", 32'(q_cnt), 32'd0);

        // jalr with wrong predicted target.
        push_only(32'h300, 2'b10, 2'b01, 1'b1, 32'h380);
        resolve(3'b100, 1'b0, 32'h3C0);
        check("t3_ghr", 32'(cmt_ghr), 32'd1);
        check("t3_bits", 32'(cmt_bits), 32'h3);
        check("t3_flush_pc", flush_pc, 32'h3C0);
        cycle();

        // Fill, overflow, drain in order.
        for (int i = 0; i < 5; i++)
            push_only(32'h1000 + 32'(i * 16), 2'(i), 2'b10, 1'b0, 32'h0);
        check("t4_full", 32'(q_full), 32'd1);
        check("t4_cnt", 32'(q_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            resolve(3'b001, 1'b0, 32'h0);
            check("t4_order", wb_instr_pc, 32'h1000 + 32'(i * 16));
        end
        check("t4_empty", 32'(q_empty), 32'd1);

        // Mispredict with 3 queued, push in the pop cycle discarded.
        for (int i = 0; i < 3; i++)
            push_only(32'h2000 + 32'(i * 4), 2'b00, 2'b00, 1'b0, 32'h0);
        bpu_push = 1'b1; bpu_pc = 32'h2100; bpu_redir = 1'b0;
        resolve(3'b010, 1'b0, 32'h2400);
        check("t5_cnt", 32'(q_cnt), 32'd0);
        check("t5_flush", 32'(flush), 32'd1);
        cycle();

        // Counter saturation at both ends.
        push_only(32'h500, 2'b11, 2'b11, 1'b1, 32'h520);
        resolve(3'b001, 1'b1, 32'h520);
        check("t6_sat_hi", 32'(cmt_bits), 32'h3);
        check("t6_hi_flush", 32'(flush), 32'd0);
        push_only(32'h600, 2'b00, 2'b00, 1'b0, 32'h0);
        resolve(3'b001, 1'b0, 32'h0);
        check("t6_sat_lo", 32'(cmt_bits), 32'h0);

        // Resolve on empty queue produces nothing.
        resolve(3'b001, 1'b1, 32'h700);
        check("t6_empty_req", 32'(cmt_req), 32'd0);

        // Reset during the recovery cycle.
        push_only(32'h800, 2'b00, 2'b01, 1'b0, 32'h0);
        resolve(3'b001, 1'b1, 32'h900);
        check("t7_flush", 32'(flush), 32'd1);
        rst = 1'b1;
        cycle();
        check("t7_rst_flush", 32'(flush), 32'd0);

        // Reset coinciding with a mispredict pop suppresses the pulse.
        push_only(32'hA00, 2'b00, 2'b01, 1'b0, 32'h0);
        rst = 1'b1;
        resolve(3'b001, 1'b1, 32'hB00);
        check("t7_rst_pop_flush", 32'(flush), 32'd0);
        check("t7_rst_pop_req", 32'(cmt_req), 32'd0);

        // Random traffic against the model, including address wrap and resets.
        for (int n = 0; n < 2000; n++) begin
            logic [2:0] typs[3];
            typs = '{3'b001, 3'b010, 3'b100};
            rst        = ($urandom_range(0, 199) == 0);
            bpu_push   = $urandom_range(0, 1);
            bpu_pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            bpu_ghr    = 2'($urandom_range(0, 3));
            bpu_bits   = 2'($urandom_range(0, 3));
            bpu_redir  = $urandom_range(0, 1);
            bpu_target = $urandom & 32'hFFFF_FFFC;
            ex_vld     = $urandom_range(0, 1);
            ex_type    = typs[$urandom_range(0, 2)];
            ex_taken   = $urandom_range(0, 1);
            ex_target  = $urandom & 32'hFFFF_FFFC;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                ex_target = mq[0].tgt;
                ex_taken  = mq[0].redir;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xcore_bpu_cmt_unit.md
Name: xcore_bpu_cmt_unit

Overview:
Back-end counterpart of the gshare branch predictor. It queues each prediction issued at fetch (PC, GHR snapshot, 2-bit counter, predicted direction and target) in program order. When execute resolves the oldest in-flight control instruction, the block compares the outcome with the queued prediction and produces the commit feedback bus: GHR repair, BIM counter update and BTB write. On a misprediction it also raises a fetch flush/redirect. It sits between the execute stage and the predictor's commit-update inputs.

Parameters:
WIDTH, 32, PC/target width
GHRLEN, 2, global history length (BIM index = {pc[9:2], ghr})
DEPTH, 4, in-flight prediction queue entries (power of 2)
CNTW, 3, width of o_q_cnt (log2(DEPTH)+1)

Ports:
i_sys_clk  in  1  clock
i_sys_rst  in  1  synchronous reset, active-high
i_bpu_push  in  1  enqueue a prediction for a fetched control instruction
i_bpu_pc  in  WIDTH  PC of predicted instruction
i_bpu_ghr  in  GHRLEN  GHR value used for the prediction
i_bpu_bits  in  2  BIM counter read at prediction
i_bpu_redir  in  1  predicted taken
i_bpu_target  in  WIDTH  predicted target
i_ex_vld  in  1  oldest control instruction resolved this cycle
i_ex_type  in  3  3'b001 branch, 3'b010 jal, 3'b100 jalr
i_ex_taken  in  1  actual direction (branch only)
i_ex_target  in  WIDTH  actual target
o_cmt_req  out  1  commit feedback valid (1-cycle pulse)
o_cmt_ghr  out  1  1 = mispredicted, 0 = correct
o_cmt_ghr_target  out  1  actual taken
o_cmt_ghr_val  out  GHRLEN  repaired GHR
o_cmt_bits  out  2  updated BIM counter
o_wb_instr_pc  out  WIDTH  PC of committed instruction
o_wb_cmt_type  out  3  type, copied from i_ex_type
o_wb_cmt_target  out  WIDTH  actual target
o_flush  out  1  mispredict flush pulse
o_flush_pc  out  WIDTH  correct fetch PC
o_q_full  out  1  queue holds DEPTH entries
o_q_empty  out  1  queue holds 0 entries
o_q_cnt  out  CNTW  entries held

Behaviour:
- Reset: all outputs 0 except o_q_empty=1. Pointers and count clear; FSM enters RUN. Reset mid-operation discards all entries and suppresses any pending pulse.
- Queue: circular, with rd/wr pointers wrapping at DEPTH.
  - Push is accepted when i_bpu_push & ~o_q_full & state==RUN. A push while full is dropped, even if a pop happens in the same cycle.
  - Pop when i_ex_vld & ~o_q_empty & state==RUN. A resolve while empty is ignored and no o_cmt_req is produced.
  - A simultaneous accepted push and pop leaves the count unchanged.
- Effective taken: te = i_ex_taken for branch; te = 1 for jal/jalr.
- Mispredict: mp = (head.redir != te) | (te & head.redir & head.target != i_ex_target).
- Counter update:
  - Branch: te ? sat(bits+1, 3) : sat(bits-1, 0).
  - jal/jalr: 2'b11.
- GHR repair: o_cmt_ghr_val = {head.ghr[GHRLEN-2:0], te}.
- Flush PC: o_flush_pc = te ? i_ex_target : head.pc + 4, with mod-2^WIDTH wrap.
- Latency: all commit outputs are registered, valid exactly 1 cycle after the pop cycle, and pulse for one cycle. o_flush = o_cmt_req & o_cmt_ghr, in the same cycle.
- FSM:
  - RUN → RECOV on a pop with mp=1. In that same transition, the whole queue (head and all younger entries) is cleared: count=0, rd=wr.
  - RECOV lasts 1 cycle (the o_flush cycle). i_bpu_push and i_ex_vld are ignored in RECOV.
  - RECOV → RUN unconditionally.
- A push coinciding with a mispredict pop is discarded, because it is wrong-path.

Test Plan:
- Reset, then push pc=0x100, ghr=2'b01, bits=2'b01, redir=0. Resolve branch not-taken → next cycle o_cmt_req=1, o_cmt_ghr=0, o_cmt_bits=2'b00, o_cmt_ghr_val=2'b10, o_flush=0, o_q_empty=1.
- Push pc=0x200, bits=2'b01, redir=0. Resolve branch taken, target=0x240 → o_cmt_ghr=1, o_cmt_bits=2'b10, o_flush=1, o_flush_pc=0x240. Pushes ignored for one cycle.
- Push pc=0x300, redir=1, target=0x380. Resolve jalr, target=0x3C0 → o_cmt_ghr=1, o_cmt_bits=2'b11, o_flush_pc=0x3C0.
- Push 4 entries → o_q_full=1, o_q_cnt=4. A 5th push is dropped. Resolve all 4 correctly → 4 pulses carrying PCs in push order, then o_q_empty=1.
- With 3 entries queued, mispredict the head → o_q_cnt=0 after the pop cycle. A push in the pop cycle is dropped.
- bits=2'b11 taken stays 2'b11. bits=2'b00 not-taken stays 2'b00. i_ex_vld on an empty queue produces no o_cmt_req. Asserting i_sys_rst during RECOV leaves o_flush=0 the following cycle.
